// File: rtl/dm_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dm_lsu_pkg;

  localparam int LAT_W = 3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lsu_align.sv
// Byte-lane steering for RV32 sub-word accesses: store strobes/data, load
// extraction with sign/zero extension, and misalign/illegal classification.
module dm_lsu_align
  import dm_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    be       = '0;
    wword    = '0;
    ldata    = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    shifted  = rword >> {lane, 3'b000};
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        ldata = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be       = 4'b0011 << lane;
        wword    = {2{wdata[15:0]}};
        ldata    = {{16{shifted[15]}}, shifted[15:0]};
        misalign = lane[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wword    = wdata;
        ldata    = rword;
        misalign = |lane;
      end
      F3_BU: begin
        ldata   = {24'd0, shifted[7:0]};
        illegal = we;
      end
      F3_HU: begin
        ldata    = {16'd0, shifted[15:0]};
        misalign = lane[0];
        illegal  = we;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Byte-addressed data memory with req/ack handshake, configurable wait states
// and error reporting for misaligned, out-of-range and illegal accesses.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t state, state_nx;
  logic [LAT_W-1:0] cnt;
  logic [31:0] mem [DEPTH];

  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      ldata;
  logic             misalign;
  logic             illegal;
  logic             acc_err;
  logic             accept;

  // The access outcome is resolved at accept and held until RESP.
  logic        pend_we;
  logic        pend_err;
  logic [31:0] pend_rd;
  logic        resp_we;
  logic        resp_err;
  logic [31:0] resp_rd;
  logic        enter_resp;

  assign word_off     = 30'((addr - BASE_ADDR) >> 2);
  assign idx          = word_off[IDX_W-1:0];
  assign out_of_range = (addr < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH));
  assign rword        = mem[idx];
  assign acc_err      = out_of_range | misalign | illegal;
  assign accept       = (state == IDLE) && req;

  dm_lsu_align u_align (
    .we       (we),
    .funct3   (funct3),
    .lane     (addr[1:0]),
    .wdata    (wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .ldata    (ldata),
    .misalign (misalign),
    .illegal  (illegal)
  );

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: if (req) state_nx = (LATENCY > 0) ? WAIT : RESP;
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = RESP;
      end
      RESP: begin
        busy     = 1'b1;
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // With zero latency RESP is entered on the accept edge itself, so the
  // output registers take the live classification instead of the held one.
  always_comb begin
    enter_resp = (state_nx == RESP) && (state != RESP);
    resp_we    = accept ? we      : pend_we;
    resp_err   = accept ? acc_err : pend_err;
    resp_rd    = accept ? ldata   : pend_rd;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      pend_we  <= 1'b0;
      pend_err <= 1'b0;
      pend_rd  <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
        pend_we  <= we;
        pend_err <= acc_err;
        pend_rd  <= acc_err ? '0 : ldata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        err <= resp_err;
        if (resp_err)     rdata <= '0;
        else if (!resp_we) rdata <= resp_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept && we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu across four latency/base configurations.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req, we, ack, err, busy;
  logic [2:0]  f3    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];

  dm_lsu #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_lat1 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .funct3(f3[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
  dm_lsu #(.DEPTH(64), .LATENCY(0), .BASE_ADDR(32'h0000_0000)) u_lat0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .funct3(f3[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
  dm_lsu #(.DEPTH(64), .LATENCY(7), .BASE_ADDR(32'h0000_0000)) u_lat7 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .funct3(f3[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));
  dm_lsu #(.DEPTH(64), .LATENCY(5), .BASE_ADDR(32'h0000_0100)) u_lat5 (
    .clk(clk), .rst(rst), .req(req[3]), .we(we[3]), .funct3(f3[3]), .addr(addr[3]),
    .wdata(wdata[3]), .rdata(rdata[3]), .ack(ack[3]), .err(err[3]), .busy(busy[3]));

  typedef struct {
    int          g;
    logic [31:0] rd;
    logic        e;
    int          at;
  } exp_t;

  exp_t sb[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 7;
      default: return 5;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  exp_t item;
  always @(negedge clk) begin
    if (rst && ack != 4'b0000) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", {28'd0, ack}, 32'd0);
      end else begin
        item = sb.pop_front();
        check("ack_lane", {28'd0, ack}, 32'(1 << item.g));
        check("ack_cycle", cyc, item.at);
        check("rdata", rdata[item.g], item.rd);
        check("err", {31'd0, err[item.g]}, {31'd0, item.e});
      end
    end
  end

  task automatic wait_done(int g);
    int n = 0;
    while ((sb.size() != 0 || busy[g]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("timeout_pending", sb.size(), 0);
  endtask

  task automatic access(int g, logic w, logic [2:0] fn, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] erd, logic ee);
    we[g] = w; f3[g] = fn; addr[g] = a; wdata[g] = wd; req[g] = 1'b1;
    sb.push_back('{g, erd, ee, cyc + 1 + lat_of(g)});
    @(negedge clk);
    req[g] = 1'b0;
    wait_done(g);
  endtask

  // Request held high across the first transaction: the second accept must
  // land in the IDLE cycle right after ack.
  task automatic held_pair(int g, logic [31:0] a, logic [31:0] erd);
    int L  = lat_of(g);
    int k  = cyc;
    int nb = 0;
    we[g] = 1'b0; f3[g] = F3_W; addr[g] = a; req[g] = 1'b1;
    sb.push_back('{g, erd, 1'b0, k + 1 + L});
    sb.push_back('{g, erd, 1'b0, k + 2*L + 3});
    for (int i = 0; i < 2*L + 6; i++) begin
      @(negedge clk);
      if (busy[g]) nb++;
      if (cyc == k + L + 3) req[g] = 1'b0;
    end
    req[g] = 1'b0;
    check("busy_cycles", nb, 2*L + 2);
    wait_done(g);
  endtask

  task automatic reset_mid(int g, logic w, logic [31:0] a, logic [31:0] wd);
    we[g] = w; f3[g] = F3_W; addr[g] = a; wdata[g] = wd; req[g] = 1'b1;
    @(negedge clk);
    req[g] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata[g], 32'd0);
    check("rst_err",   {31'd0, err[g]},  32'd0);
    check("rst_busy",  {31'd0, busy[g]}, 32'd0);
    check("rst_ack",   {31'd0, ack[g]},  32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    req = '0; we = '0;
    for (int g = 0; g < 4; g++) begin
      f3[g] = F3_W; addr[g] = '0; wdata[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("reset_rdata", rdata[g], 32'd0);
      check("reset_err",   {31'd0, err[g]},  32'd0);
      check("reset_busy",  {31'd0, busy[g]}, 32'd0);
      check("reset_ack",   {31'd0, ack[g]},  32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // LATENCY=1, BASE=0
    access(0, 1, F3_W,   32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    access(0, 1, F3_W,   32'h00, 32'hCAFEF00D, 32'h0,        1'b0);
    access(0, 0, F3_W,   32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    access(0, 0, F3_B,   32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    access(0, 0, F3_BU,  32'h13, 32'h0,        32'h000000DE, 1'b0);
    access(0, 0, F3_H,   32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    access(0, 0, F3_HU,  32'h12, 32'h0,        32'h0000DEAD, 1'b0);
    access(0, 1, F3_B,   32'h11, 32'hAABBCC55, 32'h0000DEAD, 1'b0);
    access(0, 1, F3_H,   32'h12, 32'h99991234, 32'h0000DEAD, 1'b0);
    access(0, 0, F3_W,   32'h10, 32'h0,        32'h123455EF, 1'b0);
    access(0, 0, F3_B,   32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    access(0, 0, F3_H,   32'h12, 32'h0,        32'h00001234, 1'b0);
    access(0, 0, F3_W,   32'h12, 32'h0,        32'h0,        1'b1);
    access(0, 1, F3_H,   32'h11, 32'hFFFFFFFF, 32'h0,        1'b1);
    access(0, 0, F3_W,   32'h10, 32'h0,        32'h123455EF, 1'b0);
    access(0, 1, F3_W,   32'h100, 32'h0,       32'h0,        1'b1);
    access(0, 0, F3_W,   32'h00, 32'h0,        32'hCAFEF00D, 1'b0);
    access(0, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1);
    access(0, 1, F3_BU,  32'h10, 32'h0,        32'h0,        1'b1);
    access(0, 0, F3_W,   32'h10, 32'h0,        32'h123455EF, 1'b0);
    access(0, 1, F3_W,   32'hFC, 32'h0BADCAFE, 32'h123455EF, 1'b0);
    access(0, 0, F3_W,   32'hFC, 32'h0,        32'h0BADCAFE, 1'b0);

    // LATENCY=0 and LATENCY=7 sweeps with held requests
    access(1, 1, F3_W, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    held_pair(1, 32'h20, 32'hA5A5A5A5);
    access(2, 1, F3_W, 32'h20, 32'h5A5A5A5A, 32'h0, 1'b0);
    held_pair(2, 32'h20, 32'h5A5A5A5A);

    // LATENCY=5, BASE=0x100: range edges and reset mid-operation
    access(3, 0, F3_W, 32'hFC,  32'h0,        32'h0,        1'b1);
    access(3, 1, F3_W, 32'h200, 32'h77,       32'h0,        1'b1);
    access(3, 1, F3_W, 32'h100, 32'h11111111, 32'h0,        1'b0);
    access(3, 0, F3_W, 32'h100, 32'h0,        32'h11111111, 1'b0);
    reset_mid(3, 1'b0, 32'h100, 32'h0);
    access(3, 0, F3_W, 32'h100, 32'h0,        32'h11111111, 1'b0);
    reset_mid(3, 1'b1, 32'h104, 32'h22222222);
    access(3, 0, F3_W, 32'h104, 32'h0,        32'h22222222, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
